pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the RISC pipeline, e.g. MA->RW, EX->MA, ID->EX.
- Carries one data word and one instruction word per entry, with a valid/ready handshake.
- A 2-entry skid buffer sustains full throughput while keeping in_ready registered.
- Supports synchronous flush with NOP bubble insertion, and a saturating stall counter for performance monitoring.

Parameters:
- DATA_W, 32, width of data word.
- INST_W, 32, width of instruction word.
- NOP_INST, 32'h0000_0013, instruction value presented whenever the stage holds no valid entry; width INST_W.
- CNT_W, 16, width of stall counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept; registered.
- Data_In  input  DATA_W  upstream data word.
- Inst_In  input  INST_W  upstream instruction word.
- out_valid  output  1  Data_Out/Inst_Out hold a valid entry.
- out_ready  input  1  downstream accepts.
- Data_Out  output  DATA_W  registered data word.
- Inst_Out  output  INST_W  registered instruction word.
- flush  input  1  synchronous kill of all held entries.
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (rst_n=0, asynchronous, any cycle including mid-transfer):
  - out_valid=0, Data_Out=0, Inst_Out=NOP_INST, in_ready=1, stall_cnt=0.
  - Skid entry emptied. Release is synchronous to the next clk edge.
- Storage and handshake:
  - Storage is a main register (drives outputs) plus a skid register.
  - Accept: in_valid & in_ready at the rising edge.
  - Retire: out_valid & out_ready at the rising edge.
- States (valid count): EMPTY(0), ONE(main only), TWO(main+skid).
- Transitions, per edge:
  - EMPTY: accept -> ONE, main <= input. Latency 1 cycle from input to out_valid.
  - ONE, accept & retire -> ONE, main <= input.
  - ONE, accept only -> TWO, skid <= input.
  - ONE, retire only -> EMPTY.
  - TWO, retire -> ONE, main <= skid. in_ready=0 in TWO, so no accept occurs.
  - Otherwise hold.
- in_ready is a register equal to (next state != TWO). It never depends combinationally on out_ready.
- Bubble: whenever the next state is EMPTY, Data_Out <= 0 and Inst_Out <= NOP_INST. Outputs never show stale entries while out_valid=0.
- Ordering: strict FIFO; entries are never duplicated or dropped.
- Output stability: while out_valid=1 and out_ready=0, Data_Out and Inst_Out are stable.
- Flush:
  - At the edge with flush=1, the next state is EMPTY regardless of in_valid/out_ready.
  - The same-edge input is discarded and not counted as accepted.
  - Outputs take bubble values; in_ready=1 the next cycle.
  - Flush has priority over accept and retire. stall_cnt is unaffected.
- Stall counter:
  - Increments at each edge where out_valid=1 and out_ready=0 and flush=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Cleared only by reset.
- Width rules: data and instruction paths are copied bit-exact; no sign or zero extension.

Test Plan:
- Reset then idle, in_valid=0 -> out_valid=0, Inst_Out=32'h00000013, Data_Out=0, in_ready=1, stall_cnt=0.
- Streaming: out_ready=1, three back-to-back inputs D=0xA,0xB,0xC / I=0x1,0x2,0x3 -> outputs appear one cycle later, one per cycle, in order; in_ready stays 1 throughout.
- Backpressure:
  - out_ready=0, push 0xA then 0xB -> in_ready=0 after the second accept; Data_Out=0xA held.
  - stall_cnt increments 1 per cycle; 5 stalled cycles give stall_cnt=5.
  - Then out_ready=1 -> 0xA retires, then 0xB; in_ready returns to 1.
- Flush in TWO state with in_valid=1 (D=0xD) on the same edge -> next cycle out_valid=0, Inst_Out=NOP_INST, Data_Out=0, in_ready=1; 0xD never appears.
- Asynchronous reset asserted mid-cycle while in TWO state -> outputs return to reset values immediately, without waiting for clk; after release, a single push of D=0x55 appears after 1 cycle.
- Saturation with CNT_W=3: 10 stalled cycles -> stall_cnt=7, holds at 7.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with a 2-entry skid buffer.
// The main register drives Data_Out/Inst_Out. The skid register absorbs the
// entry that arrives while the main register is stalled.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   in_valid / in_ready  - upstream handshake (in_ready is registered)
//   Data_In, Inst_In     - upstream entry
//   out_valid / out_ready- downstream handshake
//   Data_Out, Inst_Out   - held entry, bubble (0 / NOP_INST) when empty
//   flush                - synchronous kill of all held entries
//   stall_cnt            - saturating count of stalled output cycles
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013),
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] Data_In,
  input  logic [INST_W-1:0] Inst_In,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Data_Out,
  output logic [INST_W-1:0] Inst_Out,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [INST_W-1:0]   main_inst_q, main_inst_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
  logic                in_ready_q, in_ready_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                accept, retire;

  assign accept = in_valid & in_ready_q;
  assign retire = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_data_q <= '0;
      main_inst_q <= NOP_INST;
      skid_data_q <= '0;
      skid_inst_q <= NOP_INST;
      in_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_inst_q <= main_inst_d;
      skid_data_q <= skid_data_d;
      skid_inst_q <= skid_inst_d;
      in_ready_q  <= in_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_inst_d = main_inst_q;
    skid_data_d = skid_data_q;
    skid_inst_d = skid_inst_q;

    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d     = S_ONE;
            main_data_d = Data_In;
            main_inst_d = Inst_In;
          end
        end
        S_ONE: begin
          if (accept && retire) begin
            main_data_d = Data_In;
            main_inst_d = Inst_In;
          end else if (accept) begin
            state_d     = S_TWO;
            skid_data_d = Data_In;
            skid_inst_d = Inst_In;
          end else if (retire) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only a retire can happen
          if (retire) begin
            state_d     = S_ONE;
            main_data_d = skid_data_q;
            main_inst_d = skid_inst_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end

    // Empty stage always presents a bubble
    if (state_d == S_EMPTY) begin
      main_data_d = '0;
      main_inst_d = NOP_INST;
    end

    in_ready_d = (state_d != S_TWO);

    cnt_d = cnt_q;
    if (out_valid && !out_ready && !flush && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs
  always_comb begin
    out_valid = (state_q != S_EMPTY);
    in_ready  = in_ready_q;
    Data_Out  = main_data_q;
    Inst_Out  = main_inst_q;
    stall_cnt = cnt_q;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, flush;
  logic [31:0] Data_In, Inst_In;
  logic        in_ready, out_valid;
  logic [31:0] Data_Out, Inst_Out;
  logic [15:0] stall_cnt;
  logic        in_ready3, out_valid3;
  logic [31:0] Data_Out3, Inst_Out3;
  logic [2:0]  stall_cnt3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Data_In(Data_In), .Inst_In(Inst_In), .out_valid(out_valid),
    .out_ready(out_ready), .Data_Out(Data_Out), .Inst_Out(Inst_Out),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
    .Data_In(Data_In), .Inst_In(Inst_In), .out_valid(out_valid3),
    .out_ready(out_ready), .Data_Out(Data_Out3), .Inst_Out(Inst_Out3),
    .flush(flush), .stall_cnt(stall_cnt3)
  );

  // Reference model: a bounded FIFO of at most two entries
  typedef struct packed {
    logic [31:0] d;
    logic [31:0] i;
  } ent_t;

  ent_t            mq[$];
  bit              m_ready;
  longint unsigned m_cnt;

  function automatic void model_reset();
    mq.delete();
    m_ready = 1'b1;
    m_cnt   = 0;
  endfunction

  function automatic void model_edge();
    bit was_valid;
    bit ret, acc;
    was_valid = (mq.size() > 0);
    if (flush) begin
      mq.delete();
    end else begin
      ret = was_valid && out_ready;
      acc = in_valid && m_ready;
      if (ret) void'(mq.pop_front());
      if (acc) mq.push_back('{d: Data_In, i: Inst_In});
    end
    if (was_valid && !out_ready && !flush) m_cnt++;
    m_ready = (mq.size() < 2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic        ev;
    logic [31:0] ed, ei;
    longint unsigned c16, c3;
    ev  = (mq.size() > 0);
    ed  = ev ? mq[0].d : 32'h0;
    ei  = ev ? mq[0].i : NOP;
    c16 = (m_cnt > 65535) ? 65535 : m_cnt;
    c3  = (m_cnt > 7) ? 7 : m_cnt;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".Data_Out"},  64'(Data_Out),  64'(ed));
    chk({tag, ".Inst_Out"},  64'(Inst_Out),  64'(ei));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(m_ready));
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), c16);
    chk({tag, ".out_valid3"}, 64'(out_valid3), 64'(ev));
    chk({tag, ".Data_Out3"},  64'(Data_Out3),  64'(ed));
    chk({tag, ".Inst_Out3"},  64'(Inst_Out3),  64'(ei));
    chk({tag, ".in_ready3"},  64'(in_ready3),  64'(m_ready));
    chk({tag, ".stall_cnt3"}, 64'(stall_cnt3), c3);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [31:0] i,
                       input logic ordy, input logic fl);
    in_valid  = iv;
    Data_In   = d;
    Inst_In   = i;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic [31:0] i;
    logic        ordy;
    logic        fl;
    logic        e_valid;
    logic [31:0] e_d;
    logic [31:0] e_i;
    logic        e_ready;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[16];

  initial begin
    // streaming
    vecs[0]  = '{1, 32'hA, 32'h1, 1, 0,  1, 32'hA, 32'h1, 1, 0};
    vecs[1]  = '{1, 32'hB, 32'h2, 1, 0,  1, 32'hB, 32'h2, 1, 0};
    vecs[2]  = '{1, 32'hC, 32'h3, 1, 0,  1, 32'hC, 32'h3, 1, 0};
    vecs[3]  = '{0, 32'h0, 32'h0, 1, 0,  0, 32'h0, NOP,   1, 0};
    // backpressure: fill, stall five cycles, drain
    vecs[4]  = '{1, 32'hA, 32'h1, 0, 0,  1, 32'hA, 32'h1, 1, 0};
    vecs[5]  = '{1, 32'hB, 32'h2, 0, 0,  1, 32'hA, 32'h1, 0, 1};
    vecs[6]  = '{0, 32'h0, 32'h0, 0, 0,  1, 32'hA, 32'h1, 0, 2};
    vecs[7]  = '{0, 32'h0, 32'h0, 0, 0,  1, 32'hA, 32'h1, 0, 3};
    vecs[8]  = '{0, 32'h0, 32'h0, 0, 0,  1, 32'hA, 32'h1, 0, 4};
    vecs[9]  = '{0, 32'h0, 32'h0, 0, 0,  1, 32'hA, 32'h1, 0, 5};
    vecs[10] = '{0, 32'h0, 32'h0, 1, 0,  1, 32'hB, 32'h2, 1, 5};
    vecs[11] = '{0, 32'h0, 32'h0, 1, 0,  0, 32'h0, NOP,   1, 5};
    // flush in TWO with a same-edge input
    vecs[12] = '{1, 32'hE, 32'h4, 0, 0,  1, 32'hE, 32'h4, 1, 5};
    vecs[13] = '{1, 32'hF, 32'h5, 0, 0,  1, 32'hE, 32'h4, 0, 6};
    vecs[14] = '{1, 32'hD, 32'h6, 0, 1,  0, 32'h0, NOP,   1, 6};
    vecs[15] = '{0, 32'h0, 32'h0, 1, 0,  0, 32'h0, NOP,   1, 6};

    do_reset();
    // reset state, then idle
    for (int unsigned k = 0; k < 3; k++) begin
      chk("rst.out_valid", 64'(out_valid), 64'(0));
      chk("rst.Data_Out",  64'(Data_Out),  64'(0));
      chk("rst.Inst_Out",  64'(Inst_Out),  64'(NOP));
      chk("rst.in_ready",  64'(in_ready),  64'(1));
      chk("rst.stall_cnt", 64'(stall_cnt), 64'(0));
      tick();
    end

    for (int unsigned v = 0; v < 16; v++) begin
      drive(vecs[v].iv, vecs[v].d, vecs[v].i, vecs[v].ordy, vecs[v].fl);
      tick();
      chk($sformatf("vec%0d.out_valid", v), 64'(out_valid), 64'(vecs[v].e_valid));
      chk($sformatf("vec%0d.Data_Out", v),  64'(Data_Out),  64'(vecs[v].e_d));
      chk($sformatf("vec%0d.Inst_Out", v),  64'(Inst_Out),  64'(vecs[v].e_i));
      chk($sformatf("vec%0d.in_ready", v),  64'(in_ready),  64'(vecs[v].e_ready));
      chk($sformatf("vec%0d.stall_cnt", v), 64'(stall_cnt), 64'(vecs[v].e_cnt));
      check_model($sformatf("vec%0d.model", v));
    end

    // asynchronous reset while holding two entries
    do_reset();
    drive(1'b1, 32'h11, 32'h21, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h12, 32'h22, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("pre_arst.in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'(0));
    chk("arst.Data_Out",  64'(Data_Out),  64'(0));
    chk("arst.Inst_Out",  64'(Inst_Out),  64'(NOP));
    chk("arst.in_ready",  64'(in_ready),  64'(1));
    chk("arst.stall_cnt", 64'(stall_cnt), 64'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h55, 32'h77, 1'b1, 1'b0);
    tick();
    chk("post_arst.out_valid", 64'(out_valid), 64'(1));
    chk("post_arst.Data_Out",  64'(Data_Out),  64'(32'h55));
    chk("post_arst.Inst_Out",  64'(Inst_Out),  64'(32'h77));
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    check_model("post_arst.drain");

    // saturation of the 3-bit counter
    do_reset();
    drive(1'b1, 32'h99, 32'h98, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (10) tick();
    chk("sat.stall_cnt3", 64'(stall_cnt3), 64'(7));
    chk("sat.stall_cnt",  64'(stall_cnt),  64'(10));
    tick();
    chk("sat_hold.stall_cnt3", 64'(stall_cnt3), 64'(7));
    chk("sat_hold.Data_Out",   64'(Data_Out),   64'(32'h99));
    check_model("sat.model");

    // randomized traffic against the FIFO model
    do_reset();
    for (int unsigned n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, $urandom, $urandom,
            ($urandom % 3) != 0, ($urandom % 20) == 0);
      tick();
      check_model($sformatf("rand%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
